// File: rtl/core_pkg.sv
// Shared load/store definitions: funct3 encodings, LSU state encoding, legality helper.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package core_pkg;

  // RISC-V load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // RISC-V store funct3 encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  // True when funct3 names an operation this unit implements.
  function automatic logic lsu_legal(input logic store, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    if (store) begin
      case (f3)
        F3_SB, F3_SH, F3_SW: ok = 1'b1;
        default:             ok = 1'b0;
      endcase
    end else begin
      case (f3)
        F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
        default:                             ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane formatting for the LSU: store byte enables / replicated data, load extract / extend, misalignment check.
// Latency: purely combinational.
// Backpressure: none; evaluated whenever inputs change.
// Ports: i_store/i_funct3/i_addr_lo describe the op; i_wdata is rs2, i_rdata the raw memory word;
//   o_legal/o_misaligned classify the op, o_be/o_wdata drive the store lanes, o_ld_data is the extended load value.
// Build option MISALIGNED_TRAP_EN: when defined, o_misaligned flags unaligned halfword/word ops;
//   otherwise it is 0 and those ops are force-aligned by ignoring the low address bits.
module lsu_align
  import core_pkg::*;
(
  input  logic        i_store,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic        o_legal,
  output logic        o_misaligned,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ld_data
);

  logic [1:0]  w_shift;
  logic [31:0] w_shifted;

  always_comb begin
    o_legal = lsu_legal(i_store, i_funct3);

    // funct3[1:0] is the access size for both loads and stores
    case (i_funct3[1:0])
      2'b00: begin
        w_shift = i_addr_lo;
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        // addr[0] dropped: halfwords are force-aligned when not trapped
        w_shift = {i_addr_lo[1], 1'b0};
        o_be    = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_wdata = {2{i_wdata[15:0]}};
      end
      default: begin
        w_shift = 2'b00;
        o_be    = 4'b1111;
        o_wdata = i_wdata;
      end
    endcase

    w_shifted = i_rdata >> {w_shift, 3'b000};

    case (i_funct3)
      F3_LB:   o_ld_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_LH:   o_ld_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_LBU:  o_ld_data = {24'd0, w_shifted[7:0]};
      F3_LHU:  o_ld_data = {16'd0, w_shifted[15:0]};
      default: o_ld_data = w_shifted;
    endcase

`ifdef MISALIGNED_TRAP_EN
    o_misaligned = o_legal &&
                   (((i_funct3[1:0] == 2'b01) && i_addr_lo[0]) ||
                    ((i_funct3[1:0] == 2'b10) && (i_addr_lo != 2'b00)));
`else
    o_misaligned = 1'b0;
`endif
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one load/store in flight over a valid/grant/rvalid data port, aligned+extended load data to writeback.
// Latency: load 3 cycles (gnt and rvalid at earliest), store 2, fault/unsupported 1; gnt/rvalid stalls add cycles.
// Backpressure: req_ready high only in IDLE; writeback has no ready and always takes the one-cycle resp_valid pulse.
// Ports: clock/reset_n (sync, active-low); req_* from execute; dmem_* to data memory; resp_* to writeback.
// Build option MISALIGNED_TRAP_EN (in lsu_align): misaligned halfword/word ops complete at once with resp_misaligned=1.
module load_store_unit
  import core_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_store,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [4:0]            req_rd,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [3:0]            dmem_be,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_gnt,
  input  logic                  dmem_rvalid,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  resp_valid,
  output logic                  resp_we,
  output logic [4:0]            resp_rd,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_misaligned
);

  lsu_state_t            r_state;
  logic                  r_store;
  logic [2:0]            r_funct3;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [4:0]            r_rd;
  logic [3:0]            r_be;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_resp_we;
  logic [DATA_WIDTH-1:0] r_resp_data;
  logic                  r_mis;

  logic                  w_idle;
  logic                  w_in_req;
  logic                  w_done;
  logic                  w_al_store;
  logic [2:0]            w_al_funct3;
  logic [1:0]            w_al_addr_lo;
  logic                  w_legal;
  logic                  w_mis;
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_ld_data;

  assign w_idle   = (r_state == IDLE);
  assign w_in_req = (r_state == REQ);
  assign w_done   = (r_state == DONE);

  // One aligner serves both directions: it classifies and formats the incoming
  // request while idle, and extracts load data from the latched op afterwards.
  assign w_al_store   = w_idle ? req_store       : r_store;
  assign w_al_funct3  = w_idle ? req_funct3      : r_funct3;
  assign w_al_addr_lo = w_idle ? req_addr[1:0]   : r_addr[1:0];

  lsu_align u_align (
    .i_store      (w_al_store),
    .i_funct3     (w_al_funct3),
    .i_addr_lo    (w_al_addr_lo),
    .i_wdata      (req_wdata),
    .i_rdata      (dmem_rdata),
    .o_legal      (w_legal),
    .o_misaligned (w_mis),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_ld_data    (w_ld_data)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_store     <= 1'b0;
      r_funct3    <= 3'd0;
      r_addr      <= '0;
      r_rd        <= 5'd0;
      r_be        <= 4'd0;
      r_wdata     <= '0;
      r_resp_we   <= 1'b0;
      r_resp_data <= '0;
      r_mis       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_store     <= req_store;
            r_funct3    <= req_funct3;
            r_addr      <= req_addr;
            r_rd        <= req_rd;
            r_be        <= w_be;
            r_wdata     <= w_wdata;
            r_resp_data <= '0;
            r_mis       <= w_mis;
            r_resp_we   <= !req_store && w_legal && !w_mis && (req_rd != 5'd0);
            // illegal or trapped ops never touch memory
            r_state     <= (w_legal && !w_mis) ? REQ : DONE;
          end
        end
        REQ: begin
          if (dmem_gnt) begin
            r_state <= r_store ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (dmem_rvalid) begin
            r_resp_data <= w_ld_data;
            r_state     <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Outputs are state decodes gated onto latched registers; nothing from req_* reaches them directly.
  assign req_ready       = w_idle;
  assign dmem_req        = w_in_req;
  assign dmem_we         = w_in_req & r_store;
  assign dmem_addr       = w_in_req ? {r_addr[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign dmem_be         = w_in_req ? r_be : 4'd0;
  assign dmem_wdata      = w_in_req ? r_wdata : '0;
  assign resp_valid      = w_done;
  assign resp_we         = w_done & r_resp_we;
  assign resp_rd         = w_done ? r_rd : 5'd0;
  assign resp_data       = w_done ? r_resp_data : '0;
  assign resp_misaligned = w_done & r_mis;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: reset, loads with extension, stores, stalls, faults, reset aborts.
// Latency: cycle counts are measured from the cycle req_valid is presented (cycle 0).
// Backpressure: the bench plays the memory, holding dmem_gnt low to stall the request phase.
module tb_load_store_unit;

  logic        clock;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        resp_valid;
  logic        resp_we;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data;
  logic        resp_misaligned;

  int total = 0;
  int bad   = 0;

  // results of the most recent run_op
  int          o_cyc;
  int          n_req;
  logic [31:0] o_data;
  logic        o_we;
  logic        o_mis;
  logic [4:0]  o_rd;
  logic        o_after;
  logic        saw_req;
  logic        stable;
  logic        rdy_ok;
  logic [31:0] s_addr;
  logic [3:0]  s_be;
  logic [31:0] s_wdata;
  logic        s_we;

  load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_store       (req_store),
    .req_funct3      (req_funct3),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .req_rd          (req_rd),
    .dmem_req        (dmem_req),
    .dmem_we         (dmem_we),
    .dmem_addr       (dmem_addr),
    .dmem_be         (dmem_be),
    .dmem_wdata      (dmem_wdata),
    .dmem_gnt        (dmem_gnt),
    .dmem_rvalid     (dmem_rvalid),
    .dmem_rdata      (dmem_rdata),
    .resp_valid      (resp_valid),
    .resp_we         (resp_we),
    .resp_rd         (resp_rd),
    .resp_data       (resp_data),
    .resp_misaligned (resp_misaligned)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Present one op, act as memory (grant after gnt_delay stalled REQ cycles, rvalid the cycle after a load grant)
  // and record what the DUT showed. Inputs change and outputs are sampled at the falling edge.
  task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input logic [4:0] rd, input int gnt_delay, input logic [31:0] rdata);
    logic granted_load;
    logic rv_sent;
    logic done;
    @(negedge clock);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_rd = rd;
    o_cyc = -1; n_req = 0; o_data = 32'h0; o_we = 1'b0; o_mis = 1'b0; o_rd = 5'd0;
    saw_req = 1'b0; stable = 1'b1; rdy_ok = 1'b1;
    s_addr = 32'h0; s_be = 4'h0; s_wdata = 32'h0; s_we = 1'b0;
    granted_load = 1'b0; rv_sent = 1'b0; done = 1'b0;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge clock);
      req_valid = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h5A5A_5A5A;
      if (req_ready) rdy_ok = 1'b0;
      if (dmem_req) begin
        if (!saw_req) begin
          s_addr = dmem_addr; s_be = dmem_be; s_wdata = dmem_wdata; s_we = dmem_we;
        end else if (dmem_addr !== s_addr || dmem_be !== s_be || dmem_wdata !== s_wdata || dmem_we !== s_we) begin
          stable = 1'b0;
        end
        saw_req = 1'b1;
        n_req++;
        if (n_req > gnt_delay) begin
          dmem_gnt = 1'b1;
          if (!st) granted_load = 1'b1;
        end
      end else if (granted_load && !rv_sent) begin
        dmem_rvalid = 1'b1; dmem_rdata = rdata; rv_sent = 1'b1;
      end
      if (resp_valid) begin
        o_cyc = c; o_data = resp_data; o_we = resp_we; o_mis = resp_misaligned; o_rd = resp_rd;
        done = 1'b1;
      end
    end
    @(negedge clock);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    o_after = resp_valid;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0;
    req_wdata = 32'h0; req_rd = 5'd0; dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    repeat (3) @(negedge clock);
    total++;
    if ({req_ready, dmem_req, dmem_we, resp_valid, resp_we, resp_misaligned} !== 6'b100000) begin
      bad++; $display("FAIL reset_ctrl: got %b want 100000", {req_ready, dmem_req, dmem_we, resp_valid, resp_we, resp_misaligned});
    end
    total++;
    if ({dmem_addr, dmem_be, dmem_wdata, resp_data, resp_rd} !== 105'd0) begin
      bad++; $display("FAIL reset_data: got addr=%h be=%h wd=%h rdat=%h rd=%0d want all 0", dmem_addr, dmem_be, dmem_wdata, resp_data, resp_rd);
    end
    // stale gnt/rvalid after reset release must be ignored
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    total++;
    if ({req_ready, dmem_req, resp_valid} !== 3'b100) begin
      bad++; $display("FAIL reset_stale: got %b want 100", {req_ready, dmem_req, resp_valid});
    end
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
  endtask

  task automatic test_load_word();
    run_op(1'b0, 3'b010, 32'h0000_0100, 32'h0, 5'd5, 0, 32'hDEAD_BEEF);
    total++; if (o_cyc !== 3) begin bad++; $display("FAIL lw_latency: got %0d want 3", o_cyc); end
    total++; if (o_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lw_data: got %h want deadbeef", o_data); end
    total++; if ({o_we, o_mis, o_rd} !== {1'b1, 1'b0, 5'd5}) begin bad++; $display("FAIL lw_flags: got we=%b mis=%b rd=%0d want 1 0 5", o_we, o_mis, o_rd); end
    total++; if ({s_addr, s_we} !== {32'h0000_0100, 1'b0}) begin bad++; $display("FAIL lw_dmem: got addr=%h we=%b want 100 0", s_addr, s_we); end
    total++; if (o_after !== 1'b0) begin bad++; $display("FAIL lw_pulse: got %b want 0", o_after); end
  endtask

  task automatic test_load_extend();
    run_op(1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd7, 0, 32'h80FF_0000);
    total++; if (o_data !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_sext: got %h want ffffff80", o_data); end
    run_op(1'b0, 3'b100, 32'h0000_0103, 32'h0, 5'd7, 0, 32'h80FF_0000);
    total++; if (o_data !== 32'h0000_0080) begin bad++; $display("FAIL lbu_zext: got %h want 00000080", o_data); end
    run_op(1'b0, 3'b001, 32'h0000_0102, 32'h0, 5'd7, 0, 32'h80FF_0000);
    total++; if (o_data !== 32'hFFFF_80FF) begin bad++; $display("FAIL lh_sext: got %h want ffff80ff", o_data); end
    run_op(1'b0, 3'b101, 32'h0000_0102, 32'h0, 5'd7, 0, 32'h80FF_0000);
    total++; if (o_data !== 32'h0000_80FF) begin bad++; $display("FAIL lhu_zext: got %h want 000080ff", o_data); end
    run_op(1'b0, 3'b000, 32'h0000_0101, 32'h0, 5'd7, 0, 32'h1234_7F56);
    total++; if (o_data !== 32'h0000_007F) begin bad++; $display("FAIL lb_pos: got %h want 0000007f", o_data); end
  endtask

  task automatic test_store();
    run_op(1'b1, 3'b000, 32'h0000_0201, 32'h1234_56AB, 5'd3, 0, 32'h0);
    total++; if (s_be !== 4'b0010) begin bad++; $display("FAIL sb_be: got %b want 0010", s_be); end
    total++; if (s_wdata !== 32'hABAB_ABAB) begin bad++; $display("FAIL sb_wdata: got %h want abababab", s_wdata); end
    total++; if ({s_addr, s_we} !== {32'h0000_0200, 1'b1}) begin bad++; $display("FAIL sb_addr: got %h we=%b want 200 1", s_addr, s_we); end
    total++; if (o_cyc !== 2) begin bad++; $display("FAIL sb_latency: got %0d want 2", o_cyc); end
    total++; if ({o_we, o_data} !== 33'd0) begin bad++; $display("FAIL sb_resp: got we=%b data=%h want 0 0", o_we, o_data); end
    run_op(1'b1, 3'b001, 32'h0000_0202, 32'h0000_BEEF, 5'd3, 0, 32'h0);
    total++; if ({s_be, s_wdata} !== {4'b1100, 32'hBEEF_BEEF}) begin bad++; $display("FAIL sh_lanes: got be=%b wd=%h want 1100 beefbeef", s_be, s_wdata); end
  endtask

  task automatic test_gnt_stall();
    run_op(1'b1, 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 5'd1, 5, 32'h0);
    total++; if (n_req !== 6) begin bad++; $display("FAIL stall_req_cycles: got %0d want 6", n_req); end
    total++; if (stable !== 1'b1) begin bad++; $display("FAIL stall_stable: got %b want 1", stable); end
    total++; if (rdy_ok !== 1'b1) begin bad++; $display("FAIL stall_ready_low: got %b want 1", rdy_ok); end
    total++; if (o_cyc !== 7) begin bad++; $display("FAIL stall_latency: got %0d want 7", o_cyc); end
    total++; if ({s_be, s_wdata} !== {4'b1111, 32'hCAFE_F00D}) begin bad++; $display("FAIL sw_lanes: got be=%b wd=%h want 1111 cafef00d", s_be, s_wdata); end
    total++; if (o_after !== 1'b0) begin bad++; $display("FAIL stall_pulse: got %b want 0", o_after); end
  endtask

  task automatic test_rd_zero();
    run_op(1'b0, 3'b010, 32'h0000_0400, 32'h0, 5'd0, 0, 32'h1357_9BDF);
    total++; if ({o_cyc == 3, o_we} !== 2'b10) begin bad++; $display("FAIL rd0_we: got cyc=%0d we=%b want 3 0", o_cyc, o_we); end
  endtask

  task automatic test_unsupported();
    run_op(1'b0, 3'b011, 32'h0000_0500, 32'h0, 5'd9, 0, 32'hFFFF_FFFF);
    total++; if (o_cyc !== 1) begin bad++; $display("FAIL unsup_ld_latency: got %0d want 1", o_cyc); end
    total++; if ({saw_req, o_we, o_data} !== 34'd0) begin bad++; $display("FAIL unsup_ld_resp: got req=%b we=%b data=%h want 0 0 0", saw_req, o_we, o_data); end
    run_op(1'b1, 3'b100, 32'h0000_0500, 32'h1111_1111, 5'd9, 0, 32'h0);
    total++; if ({o_cyc == 1, saw_req, o_we} !== 3'b100) begin bad++; $display("FAIL unsup_st: got cyc=%0d req=%b we=%b want 1 0 0", o_cyc, saw_req, o_we); end
  endtask

  task automatic test_misaligned();
    run_op(1'b0, 3'b010, 32'h0000_0102, 32'h0, 5'd4, 0, 32'h1122_3344);
`ifdef MISALIGNED_TRAP_EN
    total++; if (o_cyc !== 1) begin bad++; $display("FAIL mis_latency: got %0d want 1", o_cyc); end
    total++; if ({o_mis, saw_req, o_we, o_data} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      bad++; $display("FAIL mis_resp: got mis=%b req=%b we=%b data=%h want 1 0 0 0", o_mis, saw_req, o_we, o_data);
    end
`else
    total++; if (o_cyc !== 3) begin bad++; $display("FAIL forcealign_latency: got %0d want 3", o_cyc); end
    total++; if ({s_addr, o_data, o_mis} !== {32'h0000_0100, 32'h1122_3344, 1'b0}) begin
      bad++; $display("FAIL forcealign_resp: got addr=%h data=%h mis=%b want 100 11223344 0", s_addr, o_data, o_mis);
    end
`endif
  endtask

  task automatic test_reset_abort();
    logic seen_resp;
    logic seen_req;
    // reset while waiting for read data
    @(negedge clock);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0600; req_rd = 5'd2;
    @(negedge clock);
    req_valid = 1'b0;
    total++; if (dmem_req !== 1'b1) begin bad++; $display("FAIL abort_req_up: got %b want 1", dmem_req); end
    dmem_gnt = 1'b1;
    @(negedge clock);
    dmem_gnt = 1'b0; reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hAAAA_5555;
    seen_resp = 1'b0; seen_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (resp_valid) seen_resp = 1'b1;
      if (dmem_req) seen_req = 1'b1;
    end
    dmem_rvalid = 1'b0;
    total++; if ({seen_resp, seen_req, req_ready} !== 3'b001) begin
      bad++; $display("FAIL abort_wait: got resp=%b req=%b ready=%b want 0 0 1", seen_resp, seen_req, req_ready);
    end
    // reset while the request phase is stalled
    @(negedge clock);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h0000_0700; req_wdata = 32'h2468_ACE0;
    @(negedge clock);
    req_valid = 1'b0; reset_n = 1'b0;
    @(negedge clock);
    total++; if ({dmem_req, dmem_be} !== 5'd0) begin bad++; $display("FAIL abort_req_drop: got req=%b be=%b want 0 0", dmem_req, dmem_be); end
    reset_n = 1'b1; dmem_gnt = 1'b1;
    seen_resp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (resp_valid) seen_resp = 1'b1;
    end
    dmem_gnt = 1'b0;
    total++; if ({seen_resp, req_ready} !== 2'b01) begin bad++; $display("FAIL abort_req: got resp=%b ready=%b want 0 1", seen_resp, req_ready); end
  endtask

  task automatic test_back_to_back();
    run_op(1'b1, 3'b010, 32'h0000_0800, 32'h0BAD_F00D, 5'd6, 0, 32'h0);
    run_op(1'b0, 3'b100, 32'h0000_0802, 32'h0, 5'd6, 0, 32'h00C3_0000);
    total++; if ({o_cyc == 3, o_data, o_we} !== {1'b1, 32'h0000_00C3, 1'b1}) begin
      bad++; $display("FAIL b2b_load: got cyc=%0d data=%h we=%b want 3 000000c3 1", o_cyc, o_data, o_we);
    end
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_load_extend();
    test_store();
    test_gnt_stall();
    test_rd_zero();
    test_unsupported();
    test_misaligned();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
